// File: rtl/rx_receiver.sv
// rx_receiver: oversampling serial packet receiver with CRC-16-CCITT check.
// Optional saturating error counter on err_count when RX_ERR_COUNT_EN is defined.
module rx_receiver #(
    parameter int CLKS_PER_BIT = 32,
    parameter int PACKET_W     = 136,
    parameter int CRC_W        = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rx_line,
    output logic [PACKET_W-1:0] rx_packet,
    output logic                rx_valid,
    output logic                crc_ok,
    output logic                crc_err,
    output logic                frame_err,
    output logic                busy,
    output logic [7:0]          err_count
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = $clog2(PACKET_W + 1);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PACKET_W - 1);
    localparam logic [CRC_W-1:0] CRC_POLY = CRC_W'(16'h1021);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t              state_q;
    logic                sync1_q;
    logic                sync2_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [IDX_W-1:0]    idx_q;
    logic [PACKET_W-1:0] shift_q;
    logic [CRC_W-1:0]    crc_q;
    logic [PACKET_W-1:0] pkt_q;
    logic                valid_q;
    logic                ok_q;
    logic                cerr_q;
    logic                ferr_q;

    logic             line;
    logic [CRC_W-1:0] crc_d;
    logic             done;

    assign line  = sync2_q;
    assign crc_d = {crc_q[CRC_W-2:0], 1'b0}
                 ^ ((crc_q[CRC_W-1] ^ line) ? CRC_POLY : '0);
    assign done  = (state_q == STOP) && (cnt_q == LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            crc_q   <= '1;
            pkt_q   <= '0;
            valid_q <= 1'b0;
            ok_q    <= 1'b0;
            cerr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= rx_line;
            sync2_q <= sync1_q;
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!line) begin
                        state_q <= START;
                        cnt_q   <= '0;
                    end
                end
                START: begin
                    if (cnt_q == HALF_CNT) begin
                        // A high line at mid start bit is treated as a glitch.
                        if (!line) begin
                            state_q <= DATA;
                            cnt_q   <= '0;
                            idx_q   <= '0;
                            crc_q   <= '1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_q == LAST_CNT) begin
                        cnt_q   <= '0;
                        shift_q <= {shift_q[PACKET_W-2:0], line};
                        crc_q   <= crc_d;
                        idx_q   <= idx_q + 1'b1;
                        if (idx_q == LAST_IDX) begin
                            state_q <= STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (done) begin
                        cnt_q   <= '0;
                        pkt_q   <= shift_q;
                        ok_q    <= (crc_q == '0);
                        cerr_q  <= (crc_q != '0);
                        ferr_q  <= !line;
                        valid_q <= 1'b1;
                        state_q <= line ? IDLE : WAIT_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    if (line) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef RX_ERR_COUNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (done && ((crc_q != '0) || !line)
                     && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = 8'h00;
`endif

    assign rx_packet = pkt_q;
    assign rx_valid  = valid_q;
    assign crc_ok    = ok_q;
    assign crc_err   = cerr_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_rx_receiver.sv
// Testbench for rx_receiver: table-driven frames checked through a scoreboard.
// A shorter bit period is used with RX_ERR_COUNT_EN to keep saturation fast.
module tb_rx_receiver;
`ifdef RX_ERR_COUNT_EN
    localparam int CPB = 2;
`else
    localparam int CPB = 8;
`endif
    localparam int PW = 136;
    localparam int GW = (CPB / 4 > 0) ? CPB / 4 : 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_line;
    logic [PW-1:0] rx_packet;
    logic          rx_valid;
    logic          crc_ok;
    logic          crc_err;
    logic          frame_err;
    logic          busy;
    logic [7:0]    err_count;

    rx_receiver #(
        .CLKS_PER_BIT(CPB),
        .PACKET_W    (PW),
        .CRC_W       (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_line  (rx_line),
        .rx_packet(rx_packet),
        .rx_valid (rx_valid),
        .crc_ok   (crc_ok),
        .crc_err  (crc_err),
        .frame_err(frame_err),
        .busy     (busy),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [119:0] payload;
        logic         corrupt;
        logic         stop;
        logic         exp_ok;
        logic         exp_ferr;
    } vec_t;

    typedef struct {
        logic [PW-1:0] pkt;
        logic          ok;
        logic          cerr;
        logic          ferr;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    vec_t vecs[6];
    int   checks = 0;
    int   passes = 0;
    int   exp_err = 0;
    int   vcount = 0;
    logic prev_v = 1'b0;

    localparam logic [119:0] P0 = 120'h0123_4567_89AB_CDEF_0011_2233_4455_66;
    localparam logic [119:0] P1 = 120'hA5A5_5A5A_FFFF_0000_1234_8001_7E7E_C3;
    localparam logic [119:0] P2 = 120'h0;

    task automatic check(input string name, input logic [PW-1:0] act,
                         input logic [PW-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    function automatic logic [15:0] crc16(input logic [119:0] p);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < 15; i++) begin
            logic [7:0] b;
            b = p[119-8*i -: 8];
            c = c ^ {b, 8'h00};
            for (int j = 0; j < 8; j++)
                c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction

    function automatic logic [PW-1:0] make_frame(input logic [119:0] p,
                                                 input logic corrupt);
        logic [PW-1:0] f;
        f = {p, crc16(p)};
        if (corrupt) f[16+60] = ~f[16+60];
        return f;
    endfunction

    task automatic push(input logic [PW-1:0] f, input logic ok,
                        input logic ferr);
        exp_t e;
        e.pkt  = f;
        e.ok   = ok;
        e.cerr = !ok;
        e.ferr = ferr;
        sbq.push_back(e);
`ifdef RX_ERR_COUNT_EN
        if ((!ok || ferr) && exp_err < 255) exp_err++;
`endif
    endtask

    task automatic drive_bit(input logic b);
        rx_line = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send(input logic [PW-1:0] f, input logic stop);
        drive_bit(1'b0);
        for (int i = PW - 1; i >= 0; i--) drive_bit(f[i]);
        drive_bit(stop);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 4 * CPB + 16) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drain"}, PW'(sbq.size()), '0);
    endtask

    task automatic check_zero(input string name);
        check({name, "_rx_packet"}, rx_packet, '0);
        check({name, "_rx_valid"}, PW'(rx_valid), '0);
        check({name, "_crc_ok"}, PW'(crc_ok), '0);
        check({name, "_crc_err"}, PW'(crc_err), '0);
        check({name, "_frame_err"}, PW'(frame_err), '0);
        check({name, "_busy"}, PW'(busy), '0);
        check({name, "_err_count"}, PW'(err_count), '0);
    endtask

    always @(posedge clk) begin
        #1;
        if (rx_valid) begin
            vcount++;
            check("valid_pulse", PW'(prev_v), '0);
            if (sbq.size() == 0) begin
                checks++;
                $display("FAIL unexpected_valid: got rx_valid=1 want 0");
            end else begin
                mon_e = sbq.pop_front();
                check("rx_packet", rx_packet, mon_e.pkt);
                check("crc_ok", PW'(crc_ok), PW'(mon_e.ok));
                check("crc_err", PW'(crc_err), PW'(mon_e.cerr));
                check("frame_err", PW'(frame_err), PW'(mon_e.ferr));
            end
        end
        prev_v = rx_valid;
    end

    initial begin
        logic [PW-1:0] f;
        logic [PW-1:0] f2;
        int            vb;

        vecs[0] = '{P0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{P0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{P0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{P1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{P1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{P2, 1'b0, 1'b1, 1'b1, 1'b0};

        rx_line = 1'b1;
        rst     = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            f = make_frame(vecs[i].payload, vecs[i].corrupt);
            push(f, vecs[i].exp_ok, vecs[i].exp_ferr);
            send(f, vecs[i].stop);
            drain($sformatf("vec%0d", i));
            if (!vecs[i].stop) begin
                repeat (2 * CPB) @(negedge clk);
                check($sformatf("vec%0d_wait_idle_busy", i), PW'(busy), 1);
                rx_line = 1'b1;
            end
            repeat (2 * CPB) @(negedge clk);
            check($sformatf("vec%0d_busy", i), PW'(busy), '0);
            check($sformatf("vec%0d_err_count", i), PW'(err_count),
                  PW'(exp_err));
        end

        f  = make_frame(P1 ^ P0, 1'b0);
        f2 = make_frame(~P0, 1'b0);
        push(f, 1'b1, 1'b0);
        push(f2, 1'b1, 1'b0);
        send(f, 1'b1);
        send(f2, 1'b1);
        drain("b2b");
        repeat (2 * CPB) @(negedge clk);
        check("b2b_busy", PW'(busy), '0);

        vb = vcount;
        rx_line = 1'b0;
        repeat (GW) @(negedge clk);
        rx_line = 1'b1;
        repeat (CPB / 2 + 3 - GW) @(negedge clk);
        check("glitch_busy", PW'(busy), '0);
        repeat (2 * CPB) @(negedge clk);
        check("glitch_no_valid", PW'(vcount), PW'(vb));

        f  = make_frame(P1, 1'b0);
        vb = vcount;
        drive_bit(1'b0);
        for (int i = 0; i < 70; i++) drive_bit(f[PW-1-i]);
        rx_line = f[PW-1-70];
        repeat (CPB / 2) @(negedge clk);
        rst     = 1'b1;
        rx_line = 1'b1;
        exp_err = 0;
        @(negedge clk);
        check_zero("midreset");
        rst = 1'b0;
        repeat (4 * CPB) @(negedge clk);
        check("midreset_no_valid", PW'(vcount), PW'(vb));
        push(f, 1'b1, 1'b0);
        send(f, 1'b1);
        drain("after_reset");
        repeat (2 * CPB) @(negedge clk);
        check("after_reset_busy", PW'(busy), '0);

`ifdef RX_ERR_COUNT_EN
        for (int k = 0; k < 260; k++) begin
            f = make_frame(P0 ^ 120'(k), 1'b1);
            push(f, 1'b0, 1'b0);
            send(f, 1'b1);
        end
        drain("sat");
        repeat (2 * CPB) @(negedge clk);
        check("sat_err_count", PW'(err_count), PW'(8'hFF));
        check("sat_model", PW'(err_count), PW'(exp_err));
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
